seven_seg_scanner: RTL



---
 rtl/seven_seg_scanner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed 7-segment scanner with per-slot blanking and frame snapshots.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_SCANNER_LZB_EN.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;

  state_t                  nxt_state;
  logic [CW-1:0]           nxt_cnt;
  logic [IW-1:0]           nxt_idx;
  logic [4*NUM_DIGITS-1:0] nxt_digits;
  logic [NUM_DIGITS-1:0]   nxt_dp;
  logic                    nxt_fs;

  logic [6:0]              sel_abcg;
  logic                    sel_dp;
  logic [NUM_DIGITS-1:0]   sel_onehot;

  function automatic logic [6:0] enc(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      4'hF: return 7'b1000111;
    endcase
  endfunction

  // Next slot position and snapshot; outputs are derived from these so
  // they line up with the state entered on the same edge.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_idx    = idx;
    nxt_digits = snap_digits;
    nxt_dp     = snap_dp;
    nxt_fs     = 1'b0;
    unique case (1'b1)
      !en: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_idx   = '0;
      end
      (en && state == IDLE): begin
        nxt_cnt    = '0;
        nxt_idx    = '0;
        nxt_digits = digits_in;
        nxt_dp     = dp_in;
        nxt_fs     = 1'b1;
        nxt_state  = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
      end
      (en && state != IDLE): begin
        if (cnt == LAST_CNT) begin
          nxt_cnt = '0;
          if (idx == LAST_IDX) begin
            nxt_idx    = '0;
            nxt_digits = digits_in;
            nxt_dp     = dp_in;
            nxt_fs     = 1'b1;
          end else begin
            nxt_idx = idx + 1'b1;
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
        nxt_state = (nxt_cnt < BLANK_CNT) ? BLANK : DRIVE;
      end
    endcase
  end

  always_comb begin
    logic       hi_zero;
    logic [3:0] code;
    sel_abcg   = '0;
    sel_dp     = 1'b0;
    sel_onehot = '0;
    hi_zero    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      code = nxt_digits[4*i +: 4];
      if (nxt_idx == IW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_dp        = nxt_dp[i];
`ifdef SEVEN_SEG_SCANNER_LZB_EN
        sel_abcg = (hi_zero && i != 0 && code == 4'h0) ? 7'b0 : enc(code);
`else
        sel_abcg = enc(code);
`endif
      end
      hi_zero = hi_zero && (code == 4'h0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      seg_out     <= '0;
      dig_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      idx         <= nxt_idx;
      snap_digits <= nxt_digits;
      snap_dp     <= nxt_dp;
      frame_start <= nxt_fs;
      seg_out     <= (nxt_state == DRIVE) ? {sel_abcg, sel_dp} : 8'h00;
      dig_sel     <= (nxt_state == DRIVE) ? sel_onehot : '0;
    end
  end

endmodule
